// File: rtl/inv_bus_receiver_if.sv
// -----------------------------------------------------------------------------
// inv_bus_receiver_if
//
// Signal bundle between the inverting-bus receiver and its surroundings. It
// carries the bus-side handshake and the core-side valid/ready interface.
// The tristate result word `r` is not part of the bundle; the receiver
// drives it as a plain port so the bus resolution stays a simple net.
//
// Signals:
//   bus_     driver -> receiver  WIDTH   inverted data word
//   stb_     driver -> receiver  1       active-low strobe
//   ack_     receiver -> driver  1       active-low acknowledge
//   re_      core -> receiver    1       active-low output enable for r
//   r_valid  receiver -> core    1       FIFO non-empty
//   r_ready  core -> receiver    1       core consumes head word
//   full     receiver -> core    1       FIFO holds DEPTH words
//   count    receiver -> core    clog2(DEPTH)+1  stored word count
//
// Modports:
//   master : the side driving the bus and consuming words (testbench/system)
//   slave  : the receiver itself
// -----------------------------------------------------------------------------
interface inv_bus_receiver_if #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
);
   logic [WIDTH-1:0]          bus_;
   logic                      stb_;
   logic                      ack_;
   logic                      re_;
   logic                      r_valid;
   logic                      r_ready;
   logic                      full;
   logic [$clog2(DEPTH):0]    count;

   modport master (
      output bus_, stb_, re_, r_ready,
      input  ack_, r_valid, full, count
   );

   modport slave (
      input  bus_, stb_, re_, r_ready,
      output ack_, r_valid, full, count
   );
endinterface

// File: rtl/inv_bus_receiver.sv
// -----------------------------------------------------------------------------
// inv_bus_receiver
//
// Far-end receiver for the inverting bus transceiver. Samples the active-low
// bus under a 4-phase strobe/acknowledge handshake, re-inverts each word to
// true polarity and buffers it in a show-ahead FIFO that the local core
// drains through a valid/ready interface.
//
// Ports:
//   clk   in   single clock, rising edge
//   rst_  in   synchronous active-low reset
//   bif   slave modport of inv_bus_receiver_if (bus handshake, valid/ready,
//              full, count, re_)
//   r     out  head-of-FIFO word in true polarity; high-Z while bif.re_ = 1
// -----------------------------------------------------------------------------
module inv_bus_receiver #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst_,
   inv_bus_receiver_if.slave  bif,
   output logic [WIDTH-1:0]   r
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic {
      IDLE = 1'b0,
      ACK  = 1'b1
   } state_t;

   state_t            state_q;
   state_t            state_d;

   logic [WIDTH-1:0]  mem [DEPTH];
   logic [AW-1:0]     wptr_q;
   logic [AW-1:0]     rptr_q;
   logic [CW-1:0]     count_q;

   logic              empty;
   logic              is_full;
   logic              pop;
   logic              space;
   logic              push;

   assign empty   = (count_q == '0);
   assign is_full = (count_q == CW'(DEPTH));

   // A pop on an empty FIFO is simply ignored.
   assign pop     = bif.r_ready && !empty;

   // A full FIFO still accepts a word when the head leaves in the same cycle.
   assign space   = !is_full || pop;

   // Capture only on the IDLE side of the handshake; in ACK the bus is ignored
   // even if it changes, so each strobe yields exactly one word.
   assign push    = (state_q == IDLE) && !bif.stb_ && space;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (push)     state_d = ACK;
         ACK:  if (bif.stb_) state_d = IDLE;
         default:            state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_) begin
         state_q <= IDLE;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         if (push) wptr_q <= wptr_q + 1'b1;
         if (pop)  rptr_q <= rptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage carries no reset; stale entries are unreachable once the
   // pointers and count are cleared.
   always_ff @(posedge clk) begin
      if (push) mem[wptr_q] <= ~bif.bus_;
   end

   // ack_ is decoded from the state register only, so there is no
   // combinational path from stb_ or bus_ to the driver.
   assign bif.ack_    = (state_q != ACK);
   assign bif.r_valid = !empty;
   assign bif.full    = is_full;
   assign bif.count   = count_q;

   assign r = bif.re_ ? {WIDTH{1'bz}} : mem[rptr_q];

endmodule

// File: tb/tb_inv_bus_receiver.sv
// -----------------------------------------------------------------------------
// tb_inv_bus_receiver
//
// Self-checking bench for inv_bus_receiver. Words are pushed to a scoreboard
// queue as they are driven onto the bus and compared against r when the
// bench pops them from the FIFO.
// -----------------------------------------------------------------------------
module tb_inv_bus_receiver;

   localparam int WIDTH = 4;
   localparam int DEPTH = 4;

   logic             clk;
   logic             rst_;
   wire  [WIDTH-1:0] r;

   inv_bus_receiver_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) b ();

   inv_bus_receiver #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk  (clk),
      .rst_ (rst_),
      .bif  (b.slave),
      .r    (r)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int               checks = 0;
   int               errors = 0;
   logic [WIDTH-1:0] sb [$];

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Advance to just after the next rising edge; outputs are sampled and new
   // inputs are driven here.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full 4-phase handshake for true word d, bounded waits on ack_.
   task automatic send_word(input logic [WIDTH-1:0] d);
      int n;
      b.bus_ = ~d;
      b.stb_ = 1'b0;
      sb.push_back(d);
      n = 0;
      do begin tick(); n++; end while (b.ack_ !== 1'b0 && n < 20);
      check("ack_low", b.ack_, 1'b0);
      b.stb_ = 1'b1;
      n = 0;
      do begin tick(); n++; end while (b.ack_ !== 1'b1 && n < 20);
      check("ack_high", b.ack_, 1'b1);
   endtask

   // Pop the head word with re_=0, comparing r against the scoreboard.
   task automatic pop_word(input string tag);
      logic [WIDTH-1:0] exp;
      b.re_ = 1'b0;
      #1;
      check({tag, "_valid"}, b.r_valid, 1'b1);
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, 1'b1, 1'b0);
      end else begin
         exp = sb.pop_front();
         check(tag, r, exp);
      end
      b.r_ready = 1'b1;
      tick();
      b.r_ready = 1'b0;
   endtask

   initial begin
      rst_      = 1'b0;
      b.stb_    = 1'b0;
      b.bus_    = ~4'h7;
      b.re_     = 1'b0;
      b.r_ready = 1'b0;

      // Reset held for two edges with the strobe already low.
      tick();
      tick();
      check("rst_ack", b.ack_, 1'b1);
      check("rst_valid", b.r_valid, 1'b0);
      check("rst_count", b.count, 0);
      check("rst_full", b.full, 1'b0);
      rst_ = 1'b1;
      sb.push_back(4'h7);
      tick();
      check("post_rst_ack", b.ack_, 1'b0);
      check("post_rst_count", b.count, 1);
      b.stb_ = 1'b1;
      tick();
      check("post_rst_ack_rel", b.ack_, 1'b1);
      pop_word("post_rst_word");
      check("post_rst_empty", b.r_valid, 1'b0);

      // Single transfer: bus 4'hA is true word 4'h5.
      b.bus_ = 4'hA;
      b.stb_ = 1'b0;
      sb.push_back(4'h5);
      tick();
      check("single_ack", b.ack_, 1'b0);
      check("single_r", r, 4'h5);
      check("single_valid", b.r_valid, 1'b1);
      check("single_count", b.count, 1);
      b.stb_ = 1'b1;
      tick();
      check("single_ack_rel", b.ack_, 1'b1);
      pop_word("single_pop");
      check("single_empty", b.r_valid, 1'b0);

      // Fill (bus F,E,D,C = words 0..3), then stall a fifth strobe.
      for (int i = 0; i < 4; i++) send_word(WIDTH'(i));
      check("fill_full", b.full, 1'b1);
      check("fill_count", b.count, 4);
      b.bus_ = 4'hB;
      b.stb_ = 1'b0;
      sb.push_back(4'h4);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("stall_ack", b.ack_, 1'b1);
      end
      check("stall_count", b.count, 4);
      // One-cycle pop lets word 4 in on the same edge.
      check("stall_head", r, sb.pop_front());
      b.r_ready = 1'b1;
      tick();
      b.r_ready = 1'b0;
      check("pushpop_count", b.count, 4);
      check("pushpop_ack", b.ack_, 1'b0);
      b.stb_ = 1'b1;
      tick();
      check("pushpop_ack_rel", b.ack_, 1'b1);
      for (int i = 0; i < 4; i++) pop_word("fill_order");
      check("fill_drained", b.count, 0);

      // Wrap-around: ten words through a four-entry FIFO.
      for (int i = 0; i < 10; i++) begin
         send_word(WIDTH'(i));
         check("wrap_count", b.count, 1);
         pop_word("wrap_order");
      end

      // Tristate behaviour.
      send_word(4'h3);
      b.re_ = 1'b1;
      #1;
      check("tri_off", r !== 4'h3, 1'b1);
      check("tri_off_count", b.count, 1);
      b.re_ = 1'b0;
      #1;
      check("tri_on", r, 4'h3);
      b.re_ = 1'b1;
      tick();
      b.re_ = 1'b0;
      tick();
      check("tri_toggle_count", b.count, 1);
      pop_word("tri_pop");

      // Reset in the middle of a handshake with two words stored.
      send_word(4'h6);
      b.bus_ = ~4'h9;
      b.stb_ = 1'b0;
      tick();
      check("mid_ack", b.ack_, 1'b0);
      check("mid_count", b.count, 2);
      rst_ = 1'b0;
      tick();
      rst_ = 1'b1;
      check("mid_rst_ack", b.ack_, 1'b1);
      check("mid_rst_count", b.count, 0);
      sb.delete();
      sb.push_back(4'h9);
      tick();
      check("recap_count", b.count, 1);
      check("recap_ack", b.ack_, 1'b0);
      b.stb_ = 1'b1;
      tick();
      pop_word("recap_word");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
